// File: rtl/countdown_pkg.sv
// countdown_pkg: BCD digit type, digit limits, run-state enum and 7-segment decode
package countdown_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {IDLE, RUNNING} state_t;
  localparam bcd_t DIGIT_MAX_DEC = 4'd9;
  localparam bcd_t DIGIT_MAX_SEX = 4'd5;
  function automatic logic [6:0] bcd_to_7seg(bcd_t d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs, BCD value, status and segment outputs of the countdown timer
interface countdown_timer_if;
  logic start_stop;
  logic load;
  logic [15:0] preset_bcd;
  logic [15:0] count_bcd;
  logic run;
  logic done;
  logic alarm;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [6:0] seg4;
  modport master (output start_stop, load, preset_bcd, input count_bcd, run, done, alarm, seg1, seg2, seg3, seg4);
  modport slave (input start_stop, load, preset_bcd, output count_bcd, run, done, alarm, seg1, seg2, seg3, seg4);
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD down-counting digit that wraps 0 -> MAX and reports a borrow
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_DEC
) (
  input  logic clock,
  input  logic reset,
  input  logic dec_en,
  input  logic load,
  input  bcd_t value,
  output bcd_t digit,
  output logic borrow
);
  assign borrow = dec_en && digit == '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) digit <= '0;
    else if (load) digit <= value;
    else if (dec_en) digit <= borrow ? MAX : digit - bcd_t'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable SS.hh BCD countdown with one-shot alarm and 7-segment outputs.
// Define AUTO_RELOAD_EN to reload the stored preset on expiry instead of stopping.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input logic clock,
  input logic reset,
  countdown_timer_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [15:0] preset_q, ld_val;
  bcd_t [3:0] digit;
  logic [3:0] borrow, dec;
  logic ss_q, alarm_q, alarm_n, done_q;
  logic run, press, valid, load_go, tick, expiry, reload, ld, unused_borrow;
  assign run     = state == RUNNING;
  assign press   = bus.start_stop && !ss_q;
  assign valid   = bus.preset_bcd[15:12] <= DIGIT_MAX_SEX && bus.preset_bcd[11:8] <= DIGIT_MAX_DEC &&
                   bus.preset_bcd[7:4] <= DIGIT_MAX_DEC && bus.preset_bcd[3:0] <= DIGIT_MAX_DEC;
  assign load_go = bus.load && !run && valid;
  assign tick    = run && pcnt == PW'(DIV - 1);
  assign expiry  = tick && digit == 16'h0001;
`ifdef AUTO_RELOAD_EN
  assign reload  = expiry && preset_q != '0;
`else
  assign reload  = 1'b0;
`endif
  assign ld      = load_go || reload;
  assign ld_val  = load_go ? bus.preset_bcd : preset_q;
  // a reload replaces the final 0001 -> 0000 step, so d0 must not also decrement
  assign dec     = {borrow[2:0], tick && !reload};
  assign unused_borrow = borrow[3];
  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_down_digit #(.MAX(g == 3 ? DIGIT_MAX_SEX : DIGIT_MAX_DEC)) u_dig (
      .clock (clock),
      .reset (reset),
      .dec_en(dec[g]),
      .load  (ld),
      .value (ld_val[4*g +: 4]),
      .digit (digit[g]),
      .borrow(borrow[g])
    );
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      pcnt     <= '0;
      ss_q     <= 1'b0;
      alarm_q  <= 1'b0;
      done_q   <= 1'b0;
      preset_q <= '0;
    end else begin
      state   <= state_n;
      pcnt    <= run && !tick ? pcnt + PW'(1) : '0;
      ss_q    <= bus.start_stop;
      alarm_q <= alarm_n;
      done_q  <= expiry;
      if (load_go) preset_q <= bus.preset_bcd;
    end
  always_comb begin
    state_n = state;
    alarm_n = alarm_q;
    if (expiry && !reload) begin
      state_n = IDLE;
      alarm_n = 1'b1;
    end else if (run && press) state_n = IDLE;
    else if (load_go) alarm_n = 1'b0;
    else if (press) begin
      alarm_n = 1'b0;
      state_n = digit != '0 ? RUNNING : IDLE;
    end
  end
  assign bus.count_bcd = digit;
  assign bus.run       = run;
  assign bus.done      = done_q;
  assign bus.alarm     = alarm_q;
  assign bus.seg1      = bcd_to_7seg(digit[0]);
  assign bus.seg2      = bcd_to_7seg(digit[1]);
  assign bus.seg3      = bcd_to_7seg(digit[2]);
  assign bus.seg4      = bcd_to_7seg(digit[3]);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with a decimal-hundredths reference model and literal checkpoints
module tb_countdown_timer;
  localparam int DIV = 10;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int m_cnt = 0, m_preset = 0, m_pre = 0;
  bit m_run = 0, m_alarm = 0, m_done = 0, m_prev = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  countdown_timer_if bus();
  countdown_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic int bcd2int(logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic logic [15:0] int2bcd(int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic bit bcd_valid(logic [15:0] b);
    return b[15:12] <= 5 && b[11:8] <= 9 && b[7:4] <= 9 && b[3:0] <= 9;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: count held as plain decimal hundredths
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_cnt = 0; m_preset = 0; m_pre = 0; m_run = 0; m_alarm = 0; m_done = 0; m_prev = 0;
    end else begin
      bit press, tick;
      press = bus.start_stop && !m_prev;
      tick = m_run && m_pre == DIV - 1;
      m_prev = bus.start_stop;
      m_done = 0;
      m_pre = (m_run && !tick) ? m_pre + 1 : 0;
      if (tick) begin
        if (m_cnt == 1 && AUTO && m_preset != 0) begin
          m_cnt = m_preset; m_done = 1;
          if (press) m_run = 0;
        end else if (m_cnt == 1) begin
          m_cnt = 0; m_run = 0; m_alarm = 1; m_done = 1;
        end else begin
          m_cnt = m_cnt - 1;
          if (press) m_run = 0;
        end
      end else if (m_run) begin
        if (press) m_run = 0;
      end else if (bus.load && bcd_valid(bus.preset_bcd)) begin
        m_cnt = bcd2int(bus.preset_bcd); m_preset = m_cnt; m_alarm = 0;
      end else if (press) begin
        m_alarm = 0; m_run = m_cnt != 0;
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      chk("model count", bus.count_bcd, int2bcd(m_cnt));
      chk("model run", bus.run, m_run);
      chk("model done", bus.done, m_done);
      chk("model alarm", bus.alarm, m_alarm);
      chk("model seg1", bus.seg1, seg_tab[m_cnt % 10]);
      chk("model seg2", bus.seg2, seg_tab[m_cnt / 10 % 10]);
      chk("model seg3", bus.seg3, seg_tab[m_cnt / 100 % 10]);
      chk("model seg4", bus.seg4, seg_tab[m_cnt / 1000 % 10]);
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press();
    bus.start_stop = 1'b1;
    cyc(1);
    bus.start_stop = 1'b0;
  endtask
  task automatic do_load(logic [15:0] v);
    bus.load = 1'b1;
    bus.preset_bcd = v;
    cyc(1);
    bus.load = 1'b0;
  endtask
  initial begin
    bus.start_stop = 1'b0;
    bus.load = 1'b0;
    bus.preset_bcd = '0;
    #3 reset = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    chk("rst count", bus.count_bcd, 16'h0000);
    chk("rst run", bus.run, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst alarm", bus.alarm, 1'b0);
    chk("rst seg1", bus.seg1, 7'h3F);
    chk("rst seg2", bus.seg2, 7'h3F);
    chk("rst seg3", bus.seg3, 7'h3F);
    chk("rst seg4", bus.seg4, 7'h3F);
    reset = 1'b1;
    cyc(1);
    do_load(16'h0012);
    chk("t2 loaded", bus.count_bcd, 16'h0012);
    press();
    chk("t2 run latency", bus.run, 1'b1);
    cyc(9);
    chk("t2 pre tick", bus.count_bcd, 16'h0012);
    cyc(1);
    chk("t2 first tick", bus.count_bcd, 16'h0011);
    cyc(109);
    chk("t2 last step", bus.count_bcd, 16'h0001);
    cyc(1);
    chk("t2 done", bus.done, 1'b1);
`ifdef AUTO_RELOAD_EN
    chk("t2 reload count", bus.count_bcd, 16'h0012);
    chk("t2 reload run", bus.run, 1'b1);
    chk("t2 reload alarm", bus.alarm, 1'b0);
    cyc(1);
    chk("t2 done pulse", bus.done, 1'b0);
    press();
    chk("t2 pause", bus.run, 1'b0);
`else
    chk("t2 expiry count", bus.count_bcd, 16'h0000);
    chk("t2 expiry run", bus.run, 1'b0);
    chk("t2 expiry alarm", bus.alarm, 1'b1);
    cyc(1);
    chk("t2 done pulse", bus.done, 1'b0);
    press();
    chk("t2 zero press run", bus.run, 1'b0);
    chk("t2 zero press alarm", bus.alarm, 1'b0);
`endif
    do_load(16'h1000);
    chk("t3 load alarm", bus.alarm, 1'b0);
    press();
    cyc(10);
    chk("t3 borrow ripple", bus.count_bcd, 16'h0999);
    press();
    chk("t3 pause", bus.run, 1'b0);
    do_load(16'h0500);
    press();
    cyc(25);
    chk("t4 two ticks", bus.count_bcd, 16'h0498);
    press();
    chk("t4 paused", bus.run, 1'b0);
    cyc(50);
    chk("t4 frozen", bus.count_bcd, 16'h0498);
    press();
    cyc(9);
    chk("t4 resume wait", bus.count_bcd, 16'h0498);
    cyc(1);
    chk("t4 resume tick", bus.count_bcd, 16'h0497);
    press();
    do_load(16'h6000);
    chk("t5 bad tens", bus.count_bcd, 16'h0497);
    do_load(16'h00A0);
    chk("t5 bad digit", bus.count_bcd, 16'h0497);
    press();
    do_load(16'h0100);
    chk("t5 load while run", bus.count_bcd, 16'h0497);
    press();
    chk("t5 paused", bus.run, 1'b0);
    bus.load = 1'b1;
    bus.preset_bcd = 16'h0200;
    bus.start_stop = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    bus.start_stop = 1'b0;
    chk("t5 load+press count", bus.count_bcd, 16'h0200);
    chk("t5 load+press run", bus.run, 1'b0);
    cyc(2);
    chk("t5 press discarded", bus.run, 1'b0);
    press();
    cyc(15);
    chk("t6 mid count", bus.count_bcd, 16'h0199);
    #2 reset = 1'b0;
    #1;
    chk("t6 async count", bus.count_bcd, 16'h0000);
    chk("t6 async run", bus.run, 1'b0);
    chk("t6 async done", bus.done, 1'b0);
    chk("t6 async alarm", bus.alarm, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1);
    do_load(16'h0003);
    press();
    cyc(29);
    chk("t6 before expiry", bus.count_bcd, 16'h0001);
    cyc(1);
    chk("t6 done", bus.done, 1'b1);
`ifdef AUTO_RELOAD_EN
    chk("t6 reload count", bus.count_bcd, 16'h0003);
    chk("t6 reload run", bus.run, 1'b1);
    chk("t6 reload alarm", bus.alarm, 1'b0);
    cyc(29);
    chk("t6 between pulses", bus.done, 1'b0);
    cyc(1);
    chk("t6 second done", bus.done, 1'b1);
    chk("t6 still running", bus.run, 1'b1);
`else
    chk("t6 expiry count", bus.count_bcd, 16'h0000);
    chk("t6 expiry alarm", bus.alarm, 1'b1);
    chk("t6 expiry run", bus.run, 1'b0);
`endif
    cyc(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
